// File: rtl/xsleena_sound_mailbox.sv
// Main-CPU to sound-CPU command mailbox: NUM_CH independent FIFOs with overflow
// policy, sticky overflow flags and a level or latched sound-CPU IRQ.
module xsleena_sound_mailbox #(
    parameter int             NUM_CH    = 2,
    parameter int             DEPTH     = 4,
    parameter int             DW        = 8,
    parameter int             OVF_MODE  = 0,
    parameter int             IRQ_MODE  = 0,
    parameter logic [DW-1:0]  EMPTY_VAL = 8'hFF,
    localparam int            CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              wr_cen,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_cen,
    input  logic [CHW-1:0]    rd_ch,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    input  logic [NUM_CH-1:0] irq_en,
    output logic              irq_n,
    output logic [NUM_CH-1:0] empty,
    output logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0]     r_mem     [NUM_CH][DEPTH];
    logic [AW-1:0]     r_wrPtr   [NUM_CH];
    logic [AW-1:0]     r_rdPtr   [NUM_CH];
    logic [CW-1:0]     r_count   [NUM_CH];
    logic [NUM_CH-1:0] r_ovf;
    logic [DW-1:0]     r_rdData;
    logic              r_rdValid;
    logic              r_irqN;
    logic              r_irqFlag;

    logic [NUM_CH-1:0] w_wrHit;
    logic [NUM_CH-1:0] w_rdHit;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_ovfEvt;
    logic [NUM_CH-1:0] w_irqLevel;
    logic [CW-1:0]     w_countNext [NUM_CH];
    logic              w_rdAny;
    logic [DW-1:0]     w_rdWord;
    logic              w_irqSet;

    // A full channel still accepts a write when the same channel pops in that
    // cycle, or always in overwrite mode (which then also drops the oldest entry).
    always_comb begin
        w_rdAny  = 1'b0;
        w_rdWord = EMPTY_VAL;
        w_irqSet = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_wrHit[c]     = wr_cen && (wr_ch == CHW'(c));
            w_rdHit[c]     = rd_cen && (rd_ch == CHW'(c));
            w_empty[c]     = (r_count[c] == '0);
            w_full[c]      = (r_count[c] == CW'(DEPTH));
            w_pop[c]       = w_rdHit[c] && !w_empty[c];
            w_ovfEvt[c]    = w_wrHit[c] && w_full[c] && !w_pop[c];
            w_push[c]      = w_wrHit[c] && (!w_full[c] || w_pop[c] || (OVF_MODE != 0));
            w_countNext[c] = r_count[c];
            if (w_push[c] && !w_pop[c] && !w_full[c])
                w_countNext[c] = r_count[c] + CW'(1);
            else if (w_pop[c] && !w_push[c])
                w_countNext[c] = r_count[c] - CW'(1);
            if (w_pop[c]) begin
                w_rdAny  = 1'b1;
                w_rdWord = r_mem[c][r_rdPtr[c]];
            end
            w_irqLevel[c] = (w_countNext[c] != '0) && irq_en[c];
            if (w_push[c] && irq_en[c])
                w_irqSet = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_push[c])
                r_mem[c][r_wrPtr[c]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wrPtr[c] <= '0;
                r_rdPtr[c] <= '0;
                r_count[c] <= '0;
            end
            r_ovf     <= '0;
            r_rdData  <= EMPTY_VAL;
            r_rdValid <= 1'b0;
            r_irqN    <= 1'b1;
            r_irqFlag <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_push[c])
                    r_wrPtr[c] <= r_wrPtr[c] + 1'b1;
                if (w_pop[c] || (w_ovfEvt[c] && (OVF_MODE != 0)))
                    r_rdPtr[c] <= r_rdPtr[c] + 1'b1;
                r_count[c] <= w_countNext[c];
                if (w_ovfEvt[c])
                    r_ovf[c] <= 1'b1;
                else if (ovf_clr[c])
                    r_ovf[c] <= 1'b0;
            end
            if (rd_cen) begin
                r_rdData  <= w_rdAny ? w_rdWord : EMPTY_VAL;
                r_rdValid <= w_rdAny;
            end else begin
                r_rdValid <= 1'b0;
            end
            r_irqN <= ~|w_irqLevel;
            if (w_irqSet)
                r_irqFlag <= 1'b1;
            else if (rd_cen)
                r_irqFlag <= 1'b0;
        end
    end

    assign rd_data  = r_rdData;
    assign rd_valid = r_rdValid;
    assign irq_n    = (IRQ_MODE != 0) ? ~r_irqFlag : r_irqN;
    assign empty    = w_empty;
    assign full     = w_full;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_xsleena_sound_mailbox.sv
// Directed bench: three mailbox variants (drop/level, overwrite/level, drop/latched)
// share one stimulus stream and are checked against hand-computed values.
module tb_xsleena_sound_mailbox;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       wr_cen;
    logic       wr_ch;
    logic [7:0] wr_data;
    logic       rd_cen;
    logic       rd_ch;
    logic [1:0] irq_en;
    logic [1:0] ovf_clr;

    logic [7:0] aRdData, bRdData, cRdData;
    logic       aRdValid, bRdValid, cRdValid;
    logic       aIrqN, bIrqN, cIrqN;
    logic [1:0] aEmpty, bEmpty, cEmpty;
    logic [1:0] aFull, bFull, cFull;
    logic [1:0] aOvf, bOvf, cOvf;

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    xsleena_sound_mailbox #(.OVF_MODE(0), .IRQ_MODE(0)) uDropLevel (
        .clk(clk), .RSTn(RSTn), .wr_cen(wr_cen), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_cen(rd_cen), .rd_ch(rd_ch), .rd_data(aRdData), .rd_valid(aRdValid),
        .irq_en(irq_en), .irq_n(aIrqN), .empty(aEmpty), .full(aFull), .ovf(aOvf),
        .ovf_clr(ovf_clr));

    xsleena_sound_mailbox #(.OVF_MODE(1), .IRQ_MODE(0)) uOverLevel (
        .clk(clk), .RSTn(RSTn), .wr_cen(wr_cen), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_cen(rd_cen), .rd_ch(rd_ch), .rd_data(bRdData), .rd_valid(bRdValid),
        .irq_en(irq_en), .irq_n(bIrqN), .empty(bEmpty), .full(bFull), .ovf(bOvf),
        .ovf_clr(ovf_clr));

    xsleena_sound_mailbox #(.OVF_MODE(0), .IRQ_MODE(1)) uDropLatch (
        .clk(clk), .RSTn(RSTn), .wr_cen(wr_cen), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_cen(rd_cen), .rd_ch(rd_ch), .rd_data(cRdData), .rd_valid(cRdValid),
        .irq_en(irq_en), .irq_n(cIrqN), .empty(cEmpty), .full(cFull), .ovf(cOvf),
        .ovf_clr(ovf_clr));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of strobes; outputs are settled 1 ns after the edge on return.
    task automatic applyStimulus(input logic we, input logic wch, input logic [7:0] wd,
                                 input logic re, input logic rch, input logic [1:0] clr);
        wr_cen  = we;
        wr_ch   = wch;
        wr_data = wd;
        rd_cen  = re;
        rd_ch   = rch;
        ovf_clr = clr;
        @(posedge clk);
        #1;
        wr_cen  = 1'b0;
        rd_cen  = 1'b0;
        ovf_clr = 2'b00;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RSTn = 1'b0; wr_cen = 1'b0; wr_ch = 1'b0; wr_data = 8'h00;
        rd_cen = 1'b0; rd_ch = 1'b0; irq_en = 2'b00; ovf_clr = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_empty", aEmpty, 2'b11);
        checkOutput("rst_full", aFull, 2'b00);
        checkOutput("rst_ovf", aOvf, 2'b00);
        checkOutput("rst_irq", aIrqN, 1'b1);
        checkOutput("rst_rdata", aRdData, 8'hFF);
        checkOutput("rst_rvalid", aRdValid, 1'b0);
        checkOutput("rst_irq_latch", cIrqN, 1'b1);
        #2 RSTn = 1'b1;

        // Basic write then pop, level and latched IRQ
        irq_en = 2'b01;
        applyStimulus(1'b1, 1'b0, 8'h8A, 1'b0, 1'b0, 2'b00);
        checkOutput("basic_irq_assert", aIrqN, 1'b0);
        checkOutput("basic_empty", aEmpty, 2'b10);
        checkOutput("basic_latch_assert", cIrqN, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        checkOutput("basic_rdata", aRdData, 8'h8A);
        checkOutput("basic_rvalid", aRdValid, 1'b1);
        checkOutput("basic_irq_release", aIrqN, 1'b1);
        checkOutput("basic_latch_release", cIrqN, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        checkOutput("basic_rvalid_pulse", aRdValid, 1'b0);
        checkOutput("basic_rdata_hold", aRdData, 8'h8A);

        // Ordering, overflow and pointer wrap on ch1 over three laps
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 1; i <= 5; i++)
                applyStimulus(1'b1, 1'b1, 8'(lap * 16 + i), 1'b0, 1'b0, 2'b00);
            checkOutput("wrap_full_drop", aFull, 2'b10);
            checkOutput("wrap_ovf_drop", aOvf, 2'b10);
            checkOutput("wrap_full_over", bFull, 2'b10);
            checkOutput("wrap_ovf_over", bOvf, 2'b10);
            for (int i = 1; i <= 4; i++) begin
                applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
                checkOutput("wrap_pop_drop", aRdData, 8'(lap * 16 + i));
                checkOutput("wrap_valid_drop", aRdValid, 1'b1);
                checkOutput("wrap_pop_over", bRdData, 8'(lap * 16 + i + 1));
            end
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
            checkOutput("wrap_empty_pop_drop", aRdData, 8'hFF);
            checkOutput("wrap_empty_valid", aRdValid, 1'b0);
            checkOutput("wrap_empty_pop_over", bRdData, 8'hFF);
            checkOutput("wrap_all_empty", aEmpty, 2'b11);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10);
            checkOutput("wrap_ovf_clr_drop", aOvf, 2'b00);
            checkOutput("wrap_ovf_clr_over", bOvf, 2'b00);
        end

        // Same-channel read and write in one clock, full then empty
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 8'(8'h11 + i), 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b1, 1'b0, 8'h15, 1'b1, 1'b0, 2'b00);
        checkOutput("coin_full_rdata", aRdData, 8'h11);
        checkOutput("coin_full_still", aFull, 2'b01);
        checkOutput("coin_full_noovf", aOvf, 2'b00);
        checkOutput("coin_full_noovf_over", bOvf, 2'b00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
            checkOutput("coin_drain_drop", aRdData, 8'(8'h12 + i));
            checkOutput("coin_drain_over", bRdData, 8'(8'h12 + i));
        end
        applyStimulus(1'b1, 1'b0, 8'h2A, 1'b1, 1'b0, 2'b00);
        checkOutput("coin_empty_rdata", aRdData, 8'hFF);
        checkOutput("coin_empty_rvalid", aRdValid, 1'b0);
        checkOutput("coin_empty_stored", aEmpty, 2'b10);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00);
        checkOutput("coin_empty_newbyte", aRdData, 8'h2A);

        // Overflow event coinciding with ovf_clr keeps the flag set
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 8'(8'h31 + i), 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b1, 1'b0, 8'h35, 1'b0, 1'b0, 2'b01);
        checkOutput("ovf_set_wins_drop", aOvf, 2'b01);
        checkOutput("ovf_set_wins_over", bOvf, 2'b01);

        // Asynchronous reset with data queued
        RSTn = 1'b0;
        #1;
        checkOutput("midrst_empty", aEmpty, 2'b11);
        checkOutput("midrst_ovf", aOvf, 2'b00);
        checkOutput("midrst_irq", aIrqN, 1'b1);
        checkOutput("midrst_rdata", aRdData, 8'hFF);
        checkOutput("midrst_ovf_over", bOvf, 2'b00);
        checkOutput("midrst_irq_latch", cIrqN, 1'b1);
        #2 RSTn = 1'b1;

        // Latched IRQ: set wins over a coincident read, then any read clears it
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 2'b00);
        checkOutput("latch_set_wins", cIrqN, 1'b0);
        checkOutput("latch_rdata_empty", cRdData, 8'hFF);
        checkOutput("level_after_write", aIrqN, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b00);
        checkOutput("latch_cleared", cIrqN, 1'b1);
        checkOutput("latch_ch0_pending", cEmpty, 2'b10);
        checkOutput("level_still_pending", aIrqN, 1'b0);
        irq_en = 2'b00;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00);
        checkOutput("level_irq_en_off", aIrqN, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
